fifo_rd_stream: RTL and testbench
=================================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side consumer for the async FIFO: drains the FIFO read port (r_en/r_empty/r_data, show-ahead:
//  r_data valid whenever r_empty=0) into a valid/ready stream with burst framing (m_last).
//  Sits entirely in the read clock domain. 2-entry output buffer sustains 1 beat/cycle with no
//  combinational path from m_ready to r_en. Stops only on burst boundaries.
// PARAMETERS
//  DATA_WIDTH  8  word width; must match the FIFO
//  BURST_LEN   4  beats per burst (>=1); m_last marks beat BURST_LEN-1
//  localparam CNT_W = (BURST_LEN>1) ? $clog2(BURST_LEN) : 1
// PORTS
//  r_clk    in   1           read-domain clock; the only clock
//  r_rst    in   1           asynchronous, active-high reset
//  enable   in   1           request to stream; sampled each cycle
//  r_en     out  1           FIFO pop strobe
//  r_empty  in   1           FIFO empty flag
//  r_data   in   DATA_WIDTH  FIFO head word (valid when r_empty=0)
//  m_valid  out  1           output beat valid
//  m_ready  in   1           downstream accept
//  m_data   out  DATA_WIDTH  output beat data
//  m_last   out  1           final beat of burst
//  idle     out  1           state==IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, buffer empty, counters 0; outputs r_en=0,
//    m_valid=0, m_data=0, m_last=0, idle=1. Buffered words discarded on reset mid-operation.
//  - States: IDLE, RUN, FINISH, DRAIN.
//    IDLE  : enable=1 -> RUN.
//    RUN   : pops allowed. enable=0 & pop_cnt==0 -> DRAIN; enable=0 & pop_cnt!=0 -> FINISH.
//    FINISH: pops allowed until pop_cnt wraps to 0 (burst completes) -> DRAIN; enable ignored.
//    DRAIN : no pops; buffer empty (occ==0) -> IDLE; enable ignored until IDLE.
//  - r_en = (state RUN|FINISH) & !r_empty & (occ!=2); occ is registered (0..2). Never r_en when
//    r_empty=1. r_data captured into buffer on the same edge as r_en.
//  - pop_cnt (CNT_W): +1 per pop, wraps BURST_LEN-1 -> 0. beat_cnt: +1 per m_valid&m_ready, same wrap.
//  - Buffer: FIFO order; m_valid = occ!=0; m_data = head; m_data/m_valid held stable while
//    m_valid&!m_ready. Simultaneous push and pop: occ unchanged, order preserved.
//  - m_last = m_valid & (beat_cnt==BURST_LEN-1). BURST_LEN=1: m_last=m_valid.
//  - Latency: FIFO non-empty with occ=0 in RUN -> r_en that cycle -> m_valid next cycle.
//  - Throughput: with m_ready=1 and FIFO non-empty, one beat/cycle steady state.
//  - FIFO momentarily empty in FINISH: wait (no r_en) until data arrives; burst never truncated.
// CONFIGURATION
//  FIFO_RD_STATS_EN defined: extra port pop_count out 16: count of r_en pulses since reset,
//    saturates at 16'hFFFF, reset to 0.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  fifo_rd_pkg: typedef enum logic [1:0] {IDLE,RUN,FINISH,DRAIN} rd_state_t; POP_CNT_MAX=16'hFFFF.
//  Sub-module fifo_skid_buf #(DATA_WIDTH): 2-entry buffer, push/pop/occ/head; top holds FSM + counters.
// TESTING
//  1. Reset mid-stream (occ=2, m_ready=0) -> next cycle m_valid=0, r_en=0, idle=1, occ=0.
//  2. FIFO holds 8 words 0x10..0x17, enable=1, m_ready=1 -> 8 beats on consecutive cycles in order,
//     m_last on 0x13 and 0x17; first m_valid one cycle after first r_en.
//  3. m_ready=0 for 5 cycles with data available -> exactly 2 pops, r_en=0 thereafter, m_data stable.
//  4. enable drops after 2nd pop of burst (BURST_LEN=4) -> 2 more pops, FINISH->DRAIN->IDLE after
//     4th beat accepted; no further r_en.
//  5. FIFO empties after 1 word in FINISH -> r_en stays 0 while r_empty=1; word written 10 cycles
//     later is popped; burst completes with m_last.
//  6. FIFO_RD_STATS_EN: 70000 pops -> pop_count=16'hFFFF held; without macro, port absent.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared state encoding and constants for the FIFO read-side streamer
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2,
      DRAIN  = 2'd3
   } rd_state_t;

   localparam logic [15:0] POP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - two-entry in-order output buffer; head is always slot0
module fifo_skid_buf #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [1:0]            occ,
   output logic [DATA_WIDTH-1:0] head
);

   logic [DATA_WIDTH-1:0] slot0;
   logic [DATA_WIDTH-1:0] slot1;

   assign head = slot0;

   // The caller never pushes when full nor pops when empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot0 <= '0;
         slot1 <= '0;
         occ   <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) slot0 <= push_data;
               else             slot1 <= push_data;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               occ   <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd2) begin
                  slot0 <= slot1;
                  slot1 <= push_data;
               end else begin
                  slot0 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains a show-ahead FIFO read port into a burst-framed valid/ready stream
// Optional FIFO_RD_STATS_EN adds a saturating pop_count output.
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic                  r_clk,
   input  logic                  r_rst,
   input  logic                  enable,
   output logic                  r_en,
   input  logic                  r_empty,
   input  logic [DATA_WIDTH-1:0] r_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  idle
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [15:0]           pop_count
`endif
);

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

   rd_state_t        state;
   logic [CNT_W-1:0] pop_cnt;
   logic [CNT_W-1:0] pop_cnt_nxt;
   logic [CNT_W-1:0] beat_cnt;
   logic [1:0]       occ;
   logic             beat_fire;

   // occ is registered, so m_ready never reaches r_en combinationally.
   assign r_en      = ((state == RUN) || (state == FINISH)) && !r_empty && (occ != 2'd2);
   assign m_valid   = (occ != 2'd0);
   assign beat_fire = m_valid && m_ready;
   assign m_last    = m_valid && (beat_cnt == LAST);
   assign idle      = (state == IDLE);

   always_comb begin
      pop_cnt_nxt = pop_cnt;
      if (r_en) pop_cnt_nxt = (pop_cnt == LAST) ? '0 : pop_cnt + 1'b1;
   end

   fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk       (r_clk),
      .rst       (r_rst),
      .push      (r_en),
      .push_data (r_data),
      .pop       (beat_fire),
      .occ       (occ),
      .head      (m_data)
   );

   // Leaving RUN looks at the count after this cycle's pop so a burst is never cut short.
   always_ff @(posedge r_clk or posedge r_rst) begin
      if (r_rst) begin
         state    <= IDLE;
         pop_cnt  <= '0;
         beat_cnt <= '0;
      end else begin
         pop_cnt <= pop_cnt_nxt;
         if (beat_fire) beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
         case (state)
            IDLE:    if (enable) state <= RUN;
            RUN:     if (!enable) state <= (pop_cnt_nxt == '0) ? DRAIN : FINISH;
            FINISH:  if (r_en && (pop_cnt == LAST)) state <= DRAIN;
            DRAIN:   if (occ == 2'd0) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FIFO_RD_STATS_EN
   always_ff @(posedge r_clk or posedge r_rst) begin
      if (r_rst) begin
         pop_count <= 16'd0;
      end else if (r_en && (pop_count != POP_CNT_MAX)) begin
         pop_count <= pop_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed bench with a queue-level model of the FIFO streamer
module tb_fifo_rd_stream;

   localparam int DW = 8;
   localparam int BL = 4;

   logic          r_clk = 1'b0;
   logic          r_rst;
   logic          enable;
   logic          r_en;
   logic          r_empty;
   logic [DW-1:0] r_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          idle;
`ifdef FIFO_RD_STATS_EN
   logic [15:0]   pop_count;
`endif

   always #5 r_clk = ~r_clk;

   fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .r_clk   (r_clk),
      .r_rst   (r_rst),
      .enable  (enable),
      .r_en    (r_en),
      .r_empty (r_empty),
      .r_data  (r_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last),
      .idle    (idle)
`ifdef FIFO_RD_STATS_EN
      ,
      .pop_count (pop_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Model: fq = FIFO contents, bq = words held by the streamer, ph = 0 idle / 1 run / 2 finish / 3 drain
   logic [DW-1:0] fq[$];
   logic [DW-1:0] bq[$];
   int ph, pops, beats, cyc;
   int ren_seen, first_ren, first_val;
   logic [DW-1:0] acc_d[$];
   bit            acc_l[$];
   int            acc_c[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void drive_fifo();
      r_empty = (fq.size() == 0);
      r_data  = (fq.size() != 0) ? fq[0] : '0;
   endfunction

   function automatic void clear_log();
      ren_seen  = 0;
      first_ren = -1;
      first_val = -1;
      acc_d.delete();
      acc_l.delete();
      acc_c.delete();
   endfunction

   // Called at a negedge after inputs are set; checks, advances model, returns at next negedge.
   task automatic cycle();
      bit e_ren, e_val, e_last, acc;
      int occ0;
      drive_fifo();
      #1;
      e_ren  = (ph == 1 || ph == 2) && fq.size() > 0 && bq.size() < 2;
      e_val  = bq.size() > 0;
      e_last = e_val && (beats % BL == BL - 1);
      chk("r_en", r_en, e_ren);
      chk("m_valid", m_valid, e_val);
      if (e_val) chk("m_data", m_data, bq[0]);
      chk("m_last", m_last, e_last);
      chk("idle", idle, ph == 0);
`ifdef FIFO_RD_STATS_EN
      chk("pop_count", pop_count, (pops > 65535) ? 65535 : pops);
`endif
      if (r_en === 1'b1) begin
         ren_seen++;
         if (first_ren < 0) first_ren = cyc;
      end
      if (m_valid === 1'b1 && first_val < 0) first_val = cyc;
      if (m_valid === 1'b1 && m_ready) begin
         acc_d.push_back(m_data);
         acc_l.push_back(m_last);
         acc_c.push_back(cyc);
      end
      acc  = e_val && m_ready;
      occ0 = bq.size();
      if (acc) begin
         void'(bq.pop_front());
         beats++;
      end
      if (e_ren) begin
         bq.push_back(fq.pop_front());
         pops++;
      end
      case (ph)
         0: if (enable) ph = 1;
         1: if (!enable) ph = (pops % BL == 0) ? 3 : 2;
         2: if (pops % BL == 0) ph = 3;
         3: if (occ0 == 0) ph = 0;
         default: ph = 0;
      endcase
      cyc++;
      @(negedge r_clk);
   endtask

   task automatic do_reset();
      r_rst  = 1'b1;
      enable = 1'b0;
      #1;
      chk("rst_r_en", r_en, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_data", m_data, 8'h00);
      chk("rst_m_last", m_last, 1'b0);
      chk("rst_idle", idle, 1'b1);
      bq.delete();
      ph = 0; pops = 0; beats = 0;
      @(negedge r_clk);
      r_rst = 1'b0;
      cyc++;
   endtask

   initial begin
      r_rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
      ph = 0; pops = 0; beats = 0; cyc = 0;
      clear_log();
      drive_fifo();
      @(negedge r_clk);
      do_reset();

      // 1: reset with two words buffered and the sink stalled
      for (int i = 0; i < 5; i++) fq.push_back(8'hA0 + 8'(i));
      enable = 1'b1; m_ready = 1'b0;
      repeat (4) cycle();
      chk("t1_pops_before_reset", ren_seen, 2);
      do_reset();
      fq.delete();
      repeat (2) cycle();

      // 2: eight words, free-flowing sink
      clear_log();
      for (int i = 0; i < 8; i++) fq.push_back(8'h10 + 8'(i));
      enable = 1'b1; m_ready = 1'b1;
      repeat (14) cycle();
      chk("t2_beats", acc_d.size(), 8);
      for (int i = 0; i < 8 && i < acc_d.size(); i++) begin
         chk("t2_data", acc_d[i], 8'h10 + 8'(i));
         chk("t2_last", acc_l[i], (i == 3 || i == 7));
         chk("t2_back_to_back", acc_c[i], acc_c[0] + i);
      end
      chk("t2_latency", first_val, first_ren + 1);

      // 3: stalled sink accepts exactly two pops and holds data
      clear_log();
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) fq.push_back(8'h20 + 8'(i));
      repeat (5) cycle();
      chk("t3_stall_pops", ren_seen, 2);
      #1 chk("t3_held_data", m_data, 8'h20);
      m_ready = 1'b1;
      clear_log();
      repeat (8) cycle();
      chk("t3_beats", acc_d.size(), 6);

      // 4: enable drops two pops into a burst
      enable = 1'b0;
      cycle();
      clear_log();
      for (int i = 0; i < 6; i++) fq.push_back(8'h30 + 8'(i));
      repeat (12) cycle();
      chk("t4_finish_pops", ren_seen, 2);
      chk("t4_idle", idle, 1'b1);
      chk("t4_beats", acc_d.size(), 2);
      if (acc_d.size() == 2) begin
         chk("t4_last_data", acc_d[1], 8'h31);
         chk("t4_last_flag", acc_l[1], 1'b1);
      end

      // 5: FIFO runs dry in FINISH; burst must still complete
      fq.delete();
      fq.push_back(8'h40); fq.push_back(8'h41);
      enable = 1'b1;
      cycle();
      enable = 1'b0;
      cycle();
      cycle();
      clear_log();
      repeat (10) cycle();
      chk("t5_dry_no_pop", ren_seen, 0);
      chk("t5_not_idle", idle, 1'b0);
      clear_log();
      fq.push_back(8'h42); fq.push_back(8'h43);
      repeat (10) cycle();
      chk("t5_late_pops", ren_seen, 2);
      chk("t5_beats", acc_d.size(), 2);
      if (acc_d.size() == 2) begin
         chk("t5_last_data", acc_d[1], 8'h43);
         chk("t5_last_flag", acc_l[1], 1'b1);
      end
      chk("t5_idle", idle, 1'b1);

`ifdef FIFO_RD_STATS_EN
      // 6: pop counter saturates
      do_reset();
      fq.delete();
      enable = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 70010; i++) begin
         while (fq.size() < 4) fq.push_back(8'(i));
         cycle();
      end
      chk("t6_saturated", pop_count, 16'hFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
